// File: rtl/ysyx_25060170_regfile_sb_pkg.sv
// ysyx_25060170_pkg: shared register-file constants and address type for decode, issue and write-back.
package ysyx_25060170_pkg;
    localparam int XLEN       = 32;
    localparam int NREG_RV32I = 32;
    localparam int NREG_RV32E = 16;
    typedef logic [$clog2(NREG_RV32I)-1:0] reg_addr_t;
endpackage

// File: rtl/ysyx_25060170_regfile_sb_if.sv
// ysyx_25060170_regfile_sb_if: read, issue-reservation and write-back bundle of the scoreboarded register file.
interface ysyx_25060170_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                wb_valid;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                wb_ready;
    logic [AW:0]         busy_cnt;
    logic                idle;
    modport master (
        output rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
        input  rd_data, rd_busy, iss_ready, wb_ready, busy_cnt, idle
    );
    modport slave (
        input  rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
        output rd_data, rd_busy, iss_ready, wb_ready, busy_cnt, idle
    );
endinterface

// File: rtl/ysyx_25060170_sb_bit.sv
// ysyx_25060170_sb_bit: one scoreboard busy flag; set beats clear when both arrive together.
module ysyx_25060170_sb_bit (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= 1'b0;
        else      q <= set ? 1'b1 : clr ? 1'b0 : q;
endmodule

// File: rtl/ysyx_25060170_regfile_sb.sv
// ysyx_25060170_regfile_sb: integer register file with write-back bypass and per-register busy scoreboard.
module ysyx_25060170_regfile_sb
    import ysyx_25060170_pkg::*;
#(
    parameter int XLEN = ysyx_25060170_pkg::XLEN,
    parameter int NREG = NREG_RV32I,
    parameter int NRD  = 2
) (
    input logic clk,
    input logic rst,
    ysyx_25060170_regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [AW:0]     cnt;
    logic            iss_fire, inc, dec;

    assign bus.iss_ready = bus.iss_rd == '0 || !busy[bus.iss_rd]
                        || (bus.wb_valid && bus.wb_addr == bus.iss_rd);
    assign iss_fire      = bus.iss_valid && bus.iss_ready;
    assign inc           = iss_fire && bus.iss_rd != '0 && !busy[bus.iss_rd];
    assign dec           = bus.wb_valid && busy[bus.wb_addr]
                        && !(iss_fire && bus.iss_rd == bus.wb_addr);
    assign bus.wb_ready  = 1'b1;
    assign bus.busy_cnt  = cnt;
    assign bus.idle      = cnt == '0;

    // regs[0] is never written, so it holds its reset value of zero
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                if (bus.wb_valid && bus.wb_addr == AW'(i)) regs[i] <= bus.wb_data;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= cnt + (AW+1)'(inc) - (AW+1)'(dec);

    assign busy[0] = 1'b0;
    for (genvar g = 1; g < NREG; g++) begin : g_sb
        ysyx_25060170_sb_bit u_bit (
            .clk (clk),
            .rst (rst),
            .set (iss_fire && bus.iss_rd == AW'(g)),
            .clr (bus.wb_valid && bus.wb_addr == AW'(g)),
            .q   (busy[g])
        );
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = bus.rd_addr[k*AW +: AW];
        assign hit = bus.wb_valid && bus.wb_addr == a && a != '0;
        assign bus.rd_data[k*XLEN +: XLEN] = hit ? bus.wb_data : regs[a];
        assign bus.rd_busy[k]              = hit ? 1'b0 : busy[a];
    end
endmodule

// File: tb/tb_ysyx_25060170_regfile_sb.sv
// tb_ysyx_25060170_regfile_sb: directed vector table plus hand-written issue-all, retire-all and async-reset sequences.
module tb_ysyx_25060170_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ysyx_25060170_regfile_sb_if bus ();
    ysyx_25060170_regfile_sb dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        iv;
        logic [4:0]  ir;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0, a1;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
        logic        rdy;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ir, input logic wv, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
        bus.iss_valid = iv;
        bus.iss_rd    = ir;
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.rd_addr   = {a1, a0};
    endtask

    task automatic chk_state(input string nm, input logic [31:0] d0, input logic b0,
                             input logic [31:0] d1, input logic b1, input logic [5:0] cnt);
        chk({nm, ".d0"},   bus.rd_data[31:0],  d0);
        chk({nm, ".b0"},   32'(bus.rd_busy[0]), 32'(b0));
        chk({nm, ".d1"},   bus.rd_data[63:32], d1);
        chk({nm, ".b1"},   32'(bus.rd_busy[1]), 32'(b1));
        chk({nm, ".cnt"},  32'(bus.busy_cnt),  32'(cnt));
        chk({nm, ".idle"}, 32'(bus.idle),      32'(cnt == 6'd0));
        chk({nm, ".wbr"},  32'(bus.wb_ready),  32'd1);
    endtask

    initial begin
        //            iv    ir    wv    wa    wd            a0    a1    d0            b0    d1            b1    rdy   cnt
        tbl[0]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 6'd0};
        tbl[1]  = '{1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 6'd0};
        tbl[2]  = '{1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 6'd1};
        tbl[3]  = '{1'b0, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b1, 6'd1};
        tbl[4]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b1, 6'd0};
        tbl[5]  = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 6'd0};
        tbl[6]  = '{1'b1, 5'd7, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd5, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 6'd1};
        tbl[7]  = '{1'b0, 5'd7, 1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 6'd1};
        tbl[8]  = '{1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,        1'b0, 32'h12345678, 1'b1, 1'b1, 6'd1};
        tbl[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 6'd1};
        tbl[10] = '{1'b1, 5'd3, 1'b1, 5'd9, 32'h55,       5'd9, 5'd3, 32'h55,       1'b0, 32'h0,        1'b0, 1'b1, 6'd1};
        tbl[11] = '{1'b1, 5'd4, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd9, 5'd3, 32'h55,       1'b0, 32'h0,        1'b1, 1'b1, 6'd2};
        tbl[12] = '{1'b0, 5'd3, 1'b0, 5'd0, 32'h0,        5'd7, 5'd4, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b1, 1'b0, 6'd2};
        tbl[13] = '{1'b0, 5'd3, 1'b1, 5'd3, 32'h33,       5'd3, 5'd4, 32'h33,       1'b0, 32'h0,        1'b1, 1'b1, 6'd2};
        tbl[14] = '{1'b0, 5'd0, 1'b1, 5'd4, 32'h44,       5'd3, 5'd4, 32'h33,       1'b0, 32'h44,       1'b0, 1'b1, 6'd1};
        tbl[15] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd4, 5'd3, 32'h44,       1'b0, 32'h33,       1'b0, 1'b1, 6'd0};

        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #12;
        chk_state("reset", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].ir, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].a0, tbl[i].a1);
            @(negedge clk);
            chk_state($sformatf("vec%0d", i), tbl[i].d0, tbl[i].b0, tbl[i].d1, tbl[i].b1, tbl[i].cnt);
            chk($sformatf("vec%0d.rdy", i), 32'(bus.iss_ready), 32'(tbl[i].rdy));
            @(posedge clk); #1;
        end

        // reserve every register back to back
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 1'b0, 5'd0, 32'h0, 5'(i), 5'd0);
            @(negedge clk);
            chk($sformatf("fill%0d.rdy", i), 32'(bus.iss_ready), 32'd1);
            chk($sformatf("fill%0d.cnt", i), 32'(bus.busy_cnt), 32'(i - 1));
            @(posedge clk); #1;
        end
        drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
        @(negedge clk);
        chk_state("full", 32'h0, 1'b1, 32'h0, 1'b1, 6'd31);
        chk("full.rdy", 32'(bus.iss_ready), 32'd0);
        @(posedge clk); #1;

        // retire in reverse order with bypassed reads
        for (int i = 31; i >= 1; i--) begin
            drive(1'b0, 5'd0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'd0);
            @(negedge clk);
            chk($sformatf("drain%0d.d0", i), bus.rd_data[31:0], 32'h100 + 32'(i));
            chk($sformatf("drain%0d.b0", i), 32'(bus.rd_busy[0]), 32'd0);
            chk($sformatf("drain%0d.cnt", i), 32'(bus.busy_cnt), 32'(i));
            @(posedge clk); #1;
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
        @(negedge clk);
        chk_state("empty", 32'h11F, 1'b0, 32'h101, 1'b0, 6'd0);
        @(posedge clk); #1;

        // asynchronous reset between edges drops reservations and data
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        @(posedge clk); #1;
        drive(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        @(negedge clk);
        chk_state("pre_rst", 32'h103, 1'b1, 32'h104, 1'b1, 6'd2);
        #2 rst = 1'b0;
        #1;
        chk_state("in_rst", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_state("post_rst", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
